// File: rtl/pvdi_pkg.sv
// Shared PVDI configuration: symbol geometry defaults and the sample type.
// Every PVDI file takes its widths and default sizes from here.
package pvdi_pkg;

  localparam int PVDI_N     = 512;
  localparam int PVDI_GUARD = 16;
  localparam int PVDI_N_SYM = 6;
  localparam int SAMPLE_W   = 14;
  localparam int SYM_CNT_W  = 4;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // Payload samples carried between the two guard bands of a symbol.
  function automatic int pay_len(input int n, input int guard);
    return n - 2 * guard;
  endfunction

endpackage

// File: rtl/pvdi_if.sv
// Payload-in / symbol-out signal bundle for the PVDI block.
// master = upstream source and symbol sink; slave = the PVDI itself.
interface pvdi_if
  import pvdi_pkg::*;
();

  sample_t di_re;
  sample_t di_im;
  logic    di_vld;
  logic    di_rdy;
  sample_t do_re;
  sample_t do_im;
  logic    do_vld;
  logic    do_sos;
  logic    frame_done;
  logic    underflow;

  modport master (
    output di_re, di_im, di_vld,
    input  di_rdy,
    input  do_re, do_im, do_vld, do_sos, frame_done, underflow
  );

  modport slave (
    input  di_re, di_im, di_vld,
    output di_rdy,
    output do_re, do_im, do_vld, do_sos, frame_done, underflow
  );

endinterface

// File: rtl/pvdi.sv
// Guard-interval inserter: frames N_SYM symbols of N samples each as
// GUARD zeros, N-2*GUARD payload samples, GUARD zeros.
module pvdi
  import pvdi_pkg::*;
#(
  parameter int N     = PVDI_N,
  parameter int GUARD = PVDI_GUARD,
  parameter int N_SYM = PVDI_N_SYM
) (
  input  logic   clk,
  input  logic   rst,
  pvdi_if.slave  io
);

  localparam int CNT_W = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRE,
    S_PAY,
    S_POST
  } state_e;

  // The sample counter runs 0..N-1 across the whole symbol, so each phase
  // ends on a fixed symbol index rather than restarting its own count.
  localparam logic [CNT_W-1:0]     PRE_LAST  = CNT_W'(GUARD - 1);
  localparam logic [CNT_W-1:0]     PAY_LAST  = CNT_W'(GUARD + pay_len(N, GUARD) - 1);
  localparam logic [CNT_W-1:0]     POST_LAST = CNT_W'(N - 1);
  localparam logic [SYM_CNT_W-1:0] SYM_LAST  = SYM_CNT_W'(N_SYM - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SYM_CNT_W-1:0] sym_q, sym_d;
  sample_t              do_re_q, do_re_d;
  sample_t              do_im_q, do_im_d;
  logic                 do_vld_q, do_vld_d;
  logic                 do_sos_q, do_sos_d;
  logic                 frame_done_q, frame_done_d;
  logic                 underflow_q, underflow_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sym_d        = sym_q;
    do_re_d      = '0;
    do_im_d      = '0;
    do_vld_d     = 1'b0;
    do_sos_d     = 1'b0;
    frame_done_d = 1'b0;
    underflow_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // The pending sample stays with upstream until PAY.
        if (io.di_vld) begin
          state_d = S_PRE;
          cnt_d   = '0;
        end
      end

      S_PRE: begin
        do_vld_d = 1'b1;
        do_sos_d = (cnt_q == '0);
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == PRE_LAST) state_d = S_PAY;
      end

      S_PAY: begin
        do_vld_d = 1'b1;
        if (io.di_vld) begin
          do_re_d = io.di_re;
          do_im_d = io.di_im;
        end else begin
          underflow_d = 1'b1;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == PAY_LAST) state_d = S_POST;
      end

      S_POST: begin
        do_vld_d = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == POST_LAST) begin
          cnt_d = '0;
          if (sym_q == SYM_LAST) begin
            frame_done_d = 1'b1;
            sym_d        = '0;
            state_d      = S_IDLE;
          end else begin
            sym_d   = sym_q + 1'b1;
            state_d = S_PRE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      sym_q        <= '0;
      do_re_q      <= '0;
      do_im_q      <= '0;
      do_vld_q     <= 1'b0;
      do_sos_q     <= 1'b0;
      frame_done_q <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sym_q        <= sym_d;
      do_re_q      <= do_re_d;
      do_im_q      <= do_im_d;
      do_vld_q     <= do_vld_d;
      do_sos_q     <= do_sos_d;
      frame_done_q <= frame_done_d;
      underflow_q  <= underflow_d;
    end
  end

  assign io.di_rdy     = (state_q == S_PAY);
  assign io.do_re      = do_re_q;
  assign io.do_im      = do_im_q;
  assign io.do_vld     = do_vld_q;
  assign io.do_sos     = do_sos_q;
  assign io.frame_done = frame_done_q;
  assign io.underflow  = underflow_q;

endmodule
